cic_interpolator: RTL and testbench
===================================

Name: cic_interpolator

Overview:
Cascaded integrator-comb interpolator. The transmit-side counterpart of the CIC decimator.
- Comb section runs at the input rate.
- Zero-stuffer raises the rate by InterpolationFactor.
- Integrator section runs at the output rate.
- Sits between the baseband sample source and the DAC/upconverter path; ready/valid handshake on both sides.

Parameters:
InputLengthBits, 12, signed input sample width.
InterpolationFactor, 8, R; output samples per accepted input; >= 2.
DelayLength, 1, M; differential delay of each comb stage; >= 1.
FilterOrder, 3, N; number of comb stages and number of integrator stages; >= 1.
InternalLengthBits, 21, width of comb/integrator arithmetic; must be >= InputLengthBits + N*clog2(R*M) - clog2(R) + 1.
OutputLengthBits, 24, output width; must be >= InternalLengthBits; out is sign-extended.

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
in  input  InputLengthBits  signed input sample
in_valid  input  1  in holds a valid sample
in_ready  output  1  block accepts in this cycle
out  output  OutputLengthBits  signed interpolated sample
out_valid  output  1  out holds a valid sample
out_ready  input  1  downstream accepts out this cycle

Behaviour:
- Clock and reset: one clock (clk); rst asynchronous, active-high.
- While rst is high: out=0, out_valid=0, in_ready=0. All comb delay lines, integrators, phase counter and held sample are cleared. Reset mid-operation discards pending samples, with no partial output afterwards.
- Arithmetic: in is sign-extended to InternalLengthBits. All add/subtract wraps modulo 2^InternalLengthBits; integrator wrap is intentional and cancelled by the combs.
- Accept: occurs when in_valid && in_ready.
  - Comb chain is computed combinationally: c0=in; ck = c(k-1) - c(k-1) delayed M accepted samples.
  - cN is registered into held_sample.
  - Comb delay lines advance only on accept.
- Step condition: step = (state==RUN) && (!out_valid || out_ready).
- State machine:
  - IDLE: in_ready=1; on accept -> RUN, phase=0.
  - RUN: zero-stuffer sample s = (phase==0) ? held_sample : 0.
    - On step, phase increments.
    - At phase==R-1 with step: if accept in the same cycle, stay in RUN with phase=0 and the new held_sample. Otherwise go to IDLE.
    - in_ready = (phase==R-1) && (!out_valid || out_ready). This allows back-to-back inputs at full output rate.
- Integrators, on step only, all updated simultaneously from old values:
  - I1 <= I1 + s; Ik <= Ik + I(k-1).
  - out <= sign-extend(I_N + I_(N-1)), i.e. the new I_N.
  - out_valid <= 1.
- out_valid clears when out_ready is high and no step occurs that cycle.
- out and out_valid are held stable while out_valid && !out_ready.
- Every accepted input produces exactly R output handshakes; none are lost or duplicated under arbitrary backpressure.
- Latency: first out_valid 2 cycles after accept (accept -> held_sample -> step -> out register).
- DC gain: (R*M)^N / R. Defaults give 64.

Decomposition:
- Shared package cic_pkg, used by both decimator and interpolator:
  - bit-growth function cic_growth(R,M,N);
  - localparam-friendly clog2 helper;
  - typedef for internal sample width.
- Sub-module cic_integrator_stage: enable, wrap-around accumulate, async reset. Instantiated N times.
- Combs stay inline; they share the accept enable and M-deep delay lines.

Test Plan:
1. Reset hold: rst=1, in=12'hAAA, in_valid=1, out_ready=0 for 1000 cycles -> out=0, out_valid=0, in_ready=0 throughout.
2. Zero input: in=0, in_valid=1, out_ready=1 for 1000 cycles -> out==0 every cycle.
3. Rate/count: in_valid=1, out_ready=1 continuous -> in_ready high exactly 1 of every 8 cycles; out_valid continuously high after first output; 100 accepts -> 800 output handshakes.
4. Backpressure: mid-stream, out_ready=0 for 100 cycles -> out and out_valid=1 frozen, in_ready=0; on release, handshake count per input is still exactly 8.
5. DC gain/sign: in=987 steady, after 200 inputs -> every out=63168; in=-5 steady -> every out=-320.
6. Reset mid-operation: assert rst asynchronously at phase 3 of a sample -> outputs 0 immediately; after release, zero input -> out stays 0 (no residue).

Source files
------------

// File: rtl/cic_pkg.sv
// Shared CIC helpers: bit-growth math, constant clog2, default internal sample type.
// Latency: n/a (package only).
// Backpressure: n/a.
package cic_pkg;

  // Default internal arithmetic width for 12-bit input, R=8, M=1, N=3, with headroom
  localparam int CIC_INT_W = 21;

  typedef logic signed [CIC_INT_W-1:0] cic_int_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } cic_state_e;

  // Ceiling log2 usable in localparam expressions; returns 0 for v <= 1
  function automatic int cic_clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Worst-case bit growth through an N-stage interpolating CIC
  function automatic int cic_growth(input int r, input int m, input int n);
    return n * cic_clog2(r * m) - cic_clog2(r);
  endfunction

endpackage

// File: rtl/cic_integrator_stage.sv
// One wrap-around integrator: acc <= acc + i_dat when i_en.
// Latency: 1 cycle from enabled input to o_acc.
// Backpressure: none; the caller gates i_en.
module cic_integrator_stage
  import cic_pkg::*;
#(
  parameter int Width = CIC_INT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_en,
  input  logic signed [Width-1:0] i_dat,
  output logic signed [Width-1:0] o_acc
);

  logic signed [Width-1:0] r_acc;

  assign o_acc = r_acc;

  // Accumulate modulo 2^Width; overflow is cancelled by the comb section
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + i_dat;
    end
  end

endmodule

// File: rtl/cic_interpolator.sv
// CIC interpolator: input-rate combs, zero-stuff by R, output-rate integrators.
// Latency: first out_valid 2 cycles after an accepted input; R outputs per input.
// Backpressure: out/out_valid hold while !out_ready; in_ready only on the last phase with a free output slot.
module cic_interpolator
  import cic_pkg::*;
#(
  parameter int InputLengthBits     = 12,
  parameter int InterpolationFactor = 8,
  parameter int DelayLength         = 1,
  parameter int FilterOrder         = 3,
  parameter int InternalLengthBits  = CIC_INT_W,
  parameter int OutputLengthBits    = 24
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic signed [InputLengthBits-1:0]  in,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic signed [OutputLengthBits-1:0] out,
  output logic                               out_valid,
  input  logic                               out_ready
);

  localparam int IW = InternalLengthBits;
  localparam int N  = FilterOrder;
  localparam int M  = DelayLength;
  localparam int PW = cic_clog2(InterpolationFactor);
  localparam logic [PW-1:0] LastPhase = PW'(InterpolationFactor - 1);

  cic_state_e r_state;
  cic_state_e w_state_nxt;
  logic [PW-1:0] r_phase;
  logic signed [IW-1:0] r_held;
  logic signed [IW-1:0] r_dly [N][M];
  logic signed [OutputLengthBits-1:0] r_out;
  logic r_out_valid;

  logic signed [IW-1:0] w_comb_in [N];
  logic signed [IW-1:0] w_comb_out;
  logic signed [IW-1:0] w_s;
  logic signed [IW-1:0] w_int_in [N];
  logic signed [IW-1:0] w_int_acc [N];
  logic signed [IW-1:0] w_out_nxt;
  logic w_last;
  logic w_out_free;
  logic w_step;
  logic w_in_ready;
  logic w_accept;

  assign w_last     = (r_phase == LastPhase);
  assign w_out_free = !r_out_valid || out_ready;
  assign w_accept   = in_valid && w_in_ready;
  assign in_ready   = w_in_ready;
  assign out        = r_out;
  assign out_valid  = r_out_valid;

  // Comb chain on the incoming sample: c(k) = c(k-1) - c(k-1) delayed M accepts
  always_comb begin
    logic signed [IW-1:0] v;
    v = IW'(in);
    for (int k = 0; k < N; k++) begin
      w_comb_in[k] = v;
      v = v - r_dly[k][M-1];
    end
    w_comb_out = v;
  end

  // Comb delay lines and held sample advance only when an input is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        for (int d = 0; d < M; d++) r_dly[k][d] <= '0;
      end
      r_held <= '0;
    end else if (w_accept) begin
      for (int k = 0; k < N; k++) begin
        r_dly[k][0] <= w_comb_in[k];
        for (int d = 1; d < M; d++) r_dly[k][d] <= r_dly[k][d-1];
      end
      r_held <= w_comb_out;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state: leave RUN after the last phase unless a new sample arrives with it
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_step && w_last && !w_accept) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: step only with a free output slot; ready on the final phase
  always_comb begin
    w_step     = 1'b0;
    w_in_ready = 1'b0;
    case (r_state)
      ST_IDLE: w_in_ready = 1'b1;
      ST_RUN: begin
        w_step     = w_out_free;
        w_in_ready = w_last && w_out_free;
      end
      default: w_in_ready = 1'b0;
    endcase
    if (rst) w_in_ready = 1'b0;
  end

  // Phase counter wraps at R-1 so IDLE always re-enters RUN at phase 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase <= '0;
    end else if (w_step) begin
      r_phase <= w_last ? '0 : r_phase + PW'(1);
    end
  end

  assign w_s = (r_phase == '0) ? r_held : '0;

  // Integrator inputs come from the previous stage's old value
  always_comb begin
    w_int_in[0] = w_s;
    for (int k = 1; k < N; k++) w_int_in[k] = w_int_acc[k-1];
  end

  for (genvar k = 0; k < N; k++) begin : g_int
    cic_integrator_stage #(.Width(IW)) u_int (
      .clk   (clk),
      .rst   (rst),
      .i_en  (w_step),
      .i_dat (w_int_in[k]),
      .o_acc (w_int_acc[k])
    );
  end

  // New value of the last integrator, computed alongside its register update
  assign w_out_nxt = w_int_acc[N-1] + w_int_in[N-1];

  // Output register: load on step, drop valid once consumed with nothing new
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else if (w_step) begin
      r_out       <= OutputLengthBits'(w_out_nxt);
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cic_interpolator.sv
// Self-checking bench: impulse-response reference model, randomized data and backpressure.
// Latency: n/a.
// Backpressure: driven randomly and in long stalls.
module tb_cic_interpolator;

  localparam int R    = 8;
  localparam int M    = 1;
  localparam int N    = 3;
  localparam int IW   = 21;
  localparam int RM   = R * M;
  localparam int HLEN = N * (RM - 1) + 1;

  logic clk;
  logic rst;
  logic signed [11:0] in_dat;
  logic in_valid;
  logic in_ready;
  logic signed [23:0] out_dat;
  logic out_valid;
  logic out_ready;

  int n_checks;
  int n_fail;
  int hs_n;
  int acc_n;
  int xq[$];
  int h[HLEN];
  logic stall_pend;
  int stall_dat;

  cic_interpolator dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in_dat),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out_dat),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Overall response = N-fold convolution of a length-RM boxcar
  task automatic build_h();
    int tmp[HLEN];
    int len;
    foreach (h[i]) h[i] = 0;
    h[0] = 1;
    len = 1;
    for (int s = 0; s < N; s++) begin
      foreach (tmp[i]) tmp[i] = 0;
      for (int i = 0; i < len; i++)
        for (int j = 0; j < RM; j++) tmp[i + j] += h[i];
      len += RM - 1;
      foreach (h[i]) h[i] = tmp[i];
    end
  endtask

  function automatic int wrap_iw(input int v);
    logic signed [IW-1:0] t;
    t = v[IW-1:0];
    return int'(t);
  endfunction

  // Output n = FIR of the zero-stuffed input stream, delayed N-1 by the integrator pipeline
  function automatic int model_y(input int n);
    int acc;
    int m;
    acc = 0;
    for (int k = 0; k < HLEN; k++) begin
      m = n - (N - 1) - k;
      if (m >= 0 && (m % R) == 0 && (m / R) < xq.size()) acc += h[k] * xq[m / R];
    end
    return wrap_iw(acc);
  endfunction

  task automatic model_reset();
    hs_n  = 0;
    acc_n = 0;
    xq.delete();
  endtask

  // Scoreboard: every output handshake against the model; held data during stalls
  always @(negedge clk) begin
    if (!rst) begin
      if (stall_pend) begin
        chk("hold_vld", int'(out_valid), 1);
        chk("hold_dat", int'(out_dat), stall_dat);
      end
      if (out_valid && out_ready) begin
        chk("out_hs", int'(out_dat), model_y(hs_n));
        hs_n++;
      end
      if (in_valid && in_ready) begin
        xq.push_back(int'(in_dat));
        acc_n++;
      end
      stall_pend = out_valid && !out_ready;
      stall_dat  = int'(out_dat);
    end else begin
      stall_pend = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    int first_c;
    int nz;
    int lows;
    int last;
    int a0;
    int h0;
    int frozen;
    bit found;

    n_checks   = 0;
    n_fail     = 0;
    stall_pend = 1'b0;
    stall_dat  = 0;
    model_reset();
    build_h();

    // Reset hold
    rst       = 1'b1;
    in_dat    = 12'hAAA;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      chk("rst_out", int'(out_dat), 0);
      chk("rst_vld", int'(out_valid), 0);
      chk("rst_rdy", int'(in_ready), 0);
    end

    // Zero input, plus first-output latency
    @(posedge clk); #1;
    rst       = 1'b0;
    in_dat    = 12'sd0;
    out_ready = 1'b1;
    first_c   = -1;
    nz        = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (out_valid && first_c < 0) first_c = c;
      if (out_dat != 0) nz++;
      @(posedge clk); #1;
    end
    chk("latency", first_c, 2);
    chk("zero_nz", nz, 0);

    // Rate: one accept per R cycles, continuous output
    a0   = acc_n;
    h0   = hs_n;
    lows = 0;
    last = -1;
    for (int c = 0; c < 800; c++) begin
      in_dat = 12'($urandom_range(0, 4095));
      @(negedge clk);
      if (!out_valid) lows++;
      if (in_valid && in_ready) begin
        if (last >= 0) chk("acc_gap", c - last, R);
        last = c;
      end
      @(posedge clk); #1;
    end
    chk("rate_acc", acc_n - a0, 100);
    chk("rate_hs", hs_n - h0, 800);
    chk("rate_vld_low", lows, 0);

    // Long stall mid-stream
    out_ready = 1'b0;
    frozen    = 0;
    for (int c = 0; c < 100; c++) begin
      in_dat = 12'($urandom_range(0, 4095));
      @(negedge clk);
      if (c == 0) frozen = int'(out_dat);
      else        chk("stall_dat", int'(out_dat), frozen);
      chk("stall_vld", int'(out_valid), 1);
      chk("stall_rdy", int'(in_ready), 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;

    // Random valid gaps and backpressure, then drain
    for (int c = 0; c < 2000; c++) begin
      in_dat    = 12'($urandom_range(0, 4095));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("count_per_in", hs_n, R * acc_n);
    @(negedge clk);
    chk("drain_vld", int'(out_valid), 0);

    // DC gain, positive then negative
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_dat   = 12'sd987;
    repeat (1700) @(posedge clk);
    #1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      chk("dc_pos_vld", int'(out_valid), 1);
      chk("dc_pos", int'(out_dat), 63168);
    end
    @(posedge clk); #1;
    in_dat = -12'sd5;
    repeat (1700) @(posedge clk);
    #1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      chk("dc_neg", int'(out_dat), -320);
    end

    // Asynchronous reset at phase 3, then no residue
    @(posedge clk); #1;
    in_dat = 12'($urandom_range(0, 4095));
    found  = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (in_valid && in_ready) found = 1'b1;
    end
    chk("t6_accept_found", int'(found), 1);
    repeat (4) @(posedge clk);
    #1;
    chk("t6_pre_vld", int'(out_valid), 1);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    chk("t6_rst_out", int'(out_dat), 0);
    chk("t6_rst_vld", int'(out_valid), 0);
    chk("t6_rst_rdy", int'(in_ready), 0);
    in_dat = 12'sd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    nz  = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (out_dat != 0) nz++;
      @(posedge clk); #1;
    end
    chk("t6_residue", nz, 0);
    chk("t6_hs_seen", int'(hs_n > 250), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
